// File: rtl/clearable_ram_if.sv
// Request/response bus of the clearable RAM, with the zero-fill control and status.
interface clearable_ram_if #(
    parameter int unsigned DATA_WIDTH = 69,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  clear_req;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_addr, req_data, clear_req,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, clear_req,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/clearable_ram.sv
// Single-port word RAM with a one-word-per-cycle zero-fill sequence and
// registered one-cycle responses; out-of-range accesses respond with an error.
module clearable_ram #(
    parameter int unsigned DATA_WIDTH = 69,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH,
    parameter int unsigned RDW_MODE   = 0
) (
    input  logic            clock,
    input  logic            reset,
    clearable_ram_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  busy_q, busy_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req_ready_c;
    logic                  accept_c;
    logic                  in_range_c;
    logic [IDX_W-1:0]      rd_idx_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  mem_we_c;
    logic [IDX_W-1:0]      mem_waddr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;

    // Request decode; the array word is only meaningful when the address is in range.
    always_comb begin
        req_ready_c = (state_q == READY) && !bus.clear_req;
        accept_c    = bus.req_valid && req_ready_c;
        in_range_c  = {1'b0, bus.req_addr} < DEPTH_EXT;
        rd_idx_c    = IDX_W'(bus.req_addr);
        rd_word_c   = mem[rd_idx_c];
    end

    // Next-state, clear sequencing, memory write port and response generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = rd_idx_c;
        mem_wdata_c = bus.req_data;

        case (state_q)
            CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = IDX_W'(cnt_q);
                mem_wdata_c = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            READY: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (accept_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !in_range_c;
                    if (!in_range_c) begin
                        rsp_data_d = '0;
                    end else if (bus.req_write) begin
                        mem_we_c   = 1'b1;
                        rsp_data_d = (RDW_MODE != 0) ? rd_word_c : bus.req_data;
                    end else begin
                        rsp_data_d = rd_word_c;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase

        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Array has no reset; writes are held off while reset is asserted.
    always_ff @(posedge clock) begin
        if (mem_we_c && reset) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_clearable_ram.sv
// Directed bench: three RAM instances (new-data, old-data, short depth) on one clock/reset.
module tb_clearable_ram;
    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;

    localparam logic [68:0] BIG = 69'h1_2345_6789_ABCD_EF01;

    clearable_ram_if #(.DATA_WIDTH(69), .ADDR_WIDTH(10)) if0 ();
    clearable_ram_if #(.DATA_WIDTH(69), .ADDR_WIDTH(10)) if1 ();
    clearable_ram_if #(.DATA_WIDTH(69), .ADDR_WIDTH(10)) if2 ();

    clearable_ram #(.DATA_WIDTH(69), .ADDR_WIDTH(10), .DEPTH(1024), .RDW_MODE(0)) u_new (
        .clock(clock), .reset(reset), .bus(if0)
    );
    clearable_ram #(.DATA_WIDTH(69), .ADDR_WIDTH(10), .DEPTH(1024), .RDW_MODE(1)) u_old (
        .clock(clock), .reset(reset), .bus(if1)
    );
    clearable_ram #(.DATA_WIDTH(69), .ADDR_WIDTH(10), .DEPTH(600), .RDW_MODE(0)) u_short (
        .clock(clock), .reset(reset), .bus(if2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic wr, input logic [9:0] a, input logic [68:0] d);
        if0.req_valid = 1'b1; if0.req_write = wr; if0.req_addr = a; if0.req_data = d;
    endtask

    task automatic req1(input logic wr, input logic [9:0] a, input logic [68:0] d);
        if1.req_valid = 1'b1; if1.req_write = wr; if1.req_addr = a; if1.req_data = d;
    endtask

    task automatic req2(input logic wr, input logic [9:0] a, input logic [68:0] d);
        if2.req_valid = 1'b1; if2.req_write = wr; if2.req_addr = a; if2.req_data = d;
    endtask

    // Counts busy cycles per instance from the current negedge; notes any req_ready while busy.
    task automatic count_busy(output int n0, output int n1, output int n2, output logic rdy);
        n0 = 0; n1 = 0; n2 = 0; rdy = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!(if0.busy || if1.busy || if2.busy)) break;
            if (if0.busy) begin n0++; rdy = rdy | if0.req_ready; end
            if (if1.busy) begin n1++; rdy = rdy | if1.req_ready; end
            if (if2.busy) begin n2++; rdy = rdy | if2.req_ready; end
            @(negedge clock);
        end
    endtask

    int   n0, n1, n2, nclr;
    logic rdy_seen, rsp_seen;

    initial begin
        reset = 1'b0;
        if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = '0; if0.req_data = '0; if0.clear_req = 1'b0;
        if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = '0; if1.req_data = '0; if1.clear_req = 1'b0;
        if2.req_valid = 1'b0; if2.req_write = 1'b0; if2.req_addr = '0; if2.req_data = '0; if2.clear_req = 1'b0;
        repeat (2) @(negedge clock);

        chkb("rst_busy", if0.busy, 1'b1);
        chkb("rst_ready", if0.req_ready, 1'b0);
        chkb("rst_rsp_valid", if0.rsp_valid, 1'b0);
        chk ("rst_rsp_data", if0.rsp_data, 69'h0);
        chkb("rst_rsp_err", if0.rsp_err, 1'b0);

        // Release reset and time the power-up clear on each instance.
        reset = 1'b1;
        count_busy(n0, n1, n2, rdy_seen);
        chk ("clr_len_1024_new", 69'(n0), 69'd1024);
        chk ("clr_len_1024_old", 69'(n1), 69'd1024);
        chk ("clr_len_600", 69'(n2), 69'd600);
        chkb("clr_ready_low", rdy_seen, 1'b0);

        // Post-clear reads, then write/read-back with new-data response.
        req0(1'b0, 10'd0, 69'h0); @(negedge clock);
        chkb("rd0_valid", if0.rsp_valid, 1'b1);
        chk ("rd0_data", if0.rsp_data, 69'h0);
        chkb("rd0_err", if0.rsp_err, 1'b0);
        req0(1'b0, 10'd511, 69'h0); @(negedge clock);
        chk ("rd511_data", if0.rsp_data, 69'h0);
        chkb("rd511_err", if0.rsp_err, 1'b0);
        req0(1'b0, 10'd1023, 69'h0); @(negedge clock);
        chkb("rd1023_valid", if0.rsp_valid, 1'b1);
        chk ("rd1023_data", if0.rsp_data, 69'h0);
        req0(1'b1, 10'd5, BIG); @(negedge clock);
        chkb("wr5_valid", if0.rsp_valid, 1'b1);
        chk ("wr5_newdata", if0.rsp_data, BIG);
        chkb("wr5_err", if0.rsp_err, 1'b0);
        req0(1'b0, 10'd5, 69'h0); @(negedge clock);
        chk ("rd5_after_wr", if0.rsp_data, BIG);
        if0.req_valid = 1'b0; @(negedge clock);
        chkb("idle_valid", if0.rsp_valid, 1'b0);
        chk ("idle_hold_data", if0.rsp_data, BIG);

        // Read of address 3 in flight when clear_req arrives; mid-clear clear_req must not restart.
        req0(1'b1, 10'd3, 69'h33); @(negedge clock);
        req0(1'b0, 10'd3, 69'h0); @(negedge clock);
        if0.req_valid = 1'b0;
        chkb("clr_inflight_valid", if0.rsp_valid, 1'b1);
        chk ("clr_inflight_data", if0.rsp_data, 69'h33);
        if0.clear_req = 1'b1;
        #1;
        nclr = 0; rsp_seen = 1'b0;
        while (!if0.req_ready && nclr < 3000) begin
            nclr++;
            if (nclr > 1 && if0.rsp_valid) rsp_seen = 1'b1;
            @(negedge clock);
            if0.clear_req = (nclr == 100);
            #1;
        end
        chk ("clr_ready_low_cycles", 69'(nclr), 69'd1025);
        chkb("clr_no_rsp", rsp_seen, 1'b0);
        req0(1'b0, 10'd3, 69'h0); @(negedge clock);
        chkb("rd3_valid", if0.rsp_valid, 1'b1);
        chk ("rd3_cleared", if0.rsp_data, 69'h0);

        // Old-data write response.
        if0.req_valid = 1'b0;
        req1(1'b1, 10'd7, 69'hAA); @(negedge clock);
        chk ("old_wr_aa_rsp", if1.rsp_data, 69'h0);
        req1(1'b1, 10'd7, 69'hBB); @(negedge clock);
        chkb("old_wr_bb_valid", if1.rsp_valid, 1'b1);
        chk ("old_wr_bb_rsp", if1.rsp_data, 69'hAA);
        req1(1'b0, 10'd7, 69'h0); @(negedge clock);
        chk ("old_rd_bb", if1.rsp_data, 69'hBB);
        if1.req_valid = 1'b0;

        // Out-of-range accesses on the 600-word instance.
        req2(1'b1, 10'd700, 69'hFF); @(negedge clock);
        chkb("oor_wr_valid", if2.rsp_valid, 1'b1);
        chkb("oor_wr_err", if2.rsp_err, 1'b1);
        chk ("oor_wr_data", if2.rsp_data, 69'h0);
        req2(1'b0, 10'd700, 69'h0); @(negedge clock);
        chkb("oor_rd_err", if2.rsp_err, 1'b1);
        chk ("oor_rd_data", if2.rsp_data, 69'h0);
        req2(1'b0, 10'd600, 69'h0); @(negedge clock);
        chkb("oor_600_err", if2.rsp_err, 1'b1);
        req2(1'b1, 10'd599, 69'h5); @(negedge clock);
        chkb("last_wr_err", if2.rsp_err, 1'b0);
        chk ("last_wr_data", if2.rsp_data, 69'h5);
        req2(1'b0, 10'd599, 69'h0); @(negedge clock);
        chkb("last_rd_err", if2.rsp_err, 1'b0);
        chk ("last_rd_data", if2.rsp_data, 69'h5);
        if2.req_valid = 1'b0;

        // Reset at clear counter 300 while another instance has a response on the bus.
        req0(1'b1, 10'd1000, 69'h77); @(negedge clock);
        if0.req_valid = 1'b0;
        if0.clear_req = 1'b1;
        @(negedge clock);
        if0.clear_req = 1'b0;
        repeat (299) @(negedge clock);
        req1(1'b0, 10'd7, 69'h0);
        @(posedge clock);
        #2;
        if1.req_valid = 1'b0;
        chkb("mid_busy", if0.busy, 1'b1);
        chkb("mid_rsp_pending", if1.rsp_valid, 1'b1);
        reset = 1'b0;
        #1;
        chkb("mid_rst_busy", if0.busy, 1'b1);
        chkb("mid_rst_ready", if0.req_ready, 1'b0);
        chkb("mid_rst_rsp_valid", if1.rsp_valid, 1'b0);
        chk ("mid_rst_rsp_data", if1.rsp_data, 69'h0);
        chkb("mid_rst_rsp_err", if2.rsp_err, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        count_busy(n0, n1, n2, rdy_seen);
        chk ("reclr_len_1024", 69'(n0), 69'd1024);
        chk ("reclr_len_600", 69'(n2), 69'd600);
        req0(1'b0, 10'd1000, 69'h0);
        req1(1'b0, 10'd7, 69'h0);
        @(negedge clock);
        chk ("reclr_rd1000", if0.rsp_data, 69'h0);
        chk ("reclr_rd7", if1.rsp_data, 69'h0);
        chkb("reclr_rd7_valid", if1.rsp_valid, 1'b1);
        if0.req_valid = 1'b0;
        if1.req_valid = 1'b0;
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clearable_ram.md
CLEARABLE_RAM -- requirements
Module: clearable_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 69, SHALL set the word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the address width in bits.
REQ-003 Parameter DEPTH, default 1<<ADDR_WIDTH, SHALL set the number of words, with 1 <= DEPTH <= 2^ADDR_WIDTH.
REQ-004 Parameter RDW_MODE, default 0, SHALL select write-response data: 0 = new data, 1 = old data.
REQ-005 Port clock, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-007 Port req_valid, input, 1 bit, SHALL indicate a request is presented.
REQ-008 Port req_ready, output, 1 bit, SHALL indicate a presented request is accepted this cycle.
REQ-009 Port req_write, input, 1 bit, SHALL select write (1) or read (0).
REQ-010 Port req_addr, input, ADDR_WIDTH, SHALL carry the word address.
REQ-011 Port req_data, input, DATA_WIDTH, SHALL carry the write data.
REQ-012 Port clear_req, input, 1 bit, SHALL request a zero-fill of the whole array.
REQ-013 Port rsp_valid, output, 1 bit, SHALL pulse for one cycle per accepted request.
REQ-014 Port rsp_data, output, DATA_WIDTH, SHALL carry response data, valid only while rsp_valid = 1.
REQ-015 Port rsp_err, output, 1 bit, SHALL flag an out-of-range access, valid only while rsp_valid = 1.
REQ-016 Port busy, output, 1 bit, SHALL be 1 while the clear sequence runs.

Function
REQ-017 The block SHALL have two states: CLEAR and READY.
REQ-018 req_ready SHALL be 1 combinationally iff state = READY and clear_req = 0; a request is accepted iff req_valid && req_ready.
REQ-019 In CLEAR, one word per cycle SHALL be written with zero at a counter running 0..DEPTH-1; the transition to READY SHALL occur on the cycle after address DEPTH-1 is written; CLEAR SHALL therefore take exactly DEPTH cycles.
REQ-020 busy SHALL be 1 exactly while state = CLEAR.
REQ-021 clear_req = 1 in READY SHALL enter CLEAR with the counter at 0 on the next edge; clear_req during CLEAR SHALL be ignored (no restart).
REQ-022 An accepted read in cycle N SHALL give rsp_valid = 1 in cycle N+1, with rsp_data = the word at req_addr.
REQ-023 An accepted write in cycle N SHALL update the word on the edge ending cycle N and give rsp_valid = 1 in cycle N+1.
REQ-024 The write response rsp_data SHALL be req_data when RDW_MODE = 0, or the prior contents when RDW_MODE = 1.
REQ-025 Back-to-back accepted requests SHALL be sustained at one per cycle; a read at cycle N+1 of the address written at N SHALL return the written data.
REQ-026 Requests with req_addr >= DEPTH SHALL be accepted, SHALL leave memory unchanged, and SHALL respond with rsp_data = 0 and rsp_err = 1.
REQ-027 rsp_err SHALL be 0 on every in-range response.
REQ-028 A response for a request accepted in the cycle before a clear_req SHALL still be delivered in the next cycle, unchanged.
REQ-029 rsp_valid SHALL be 0 in every cycle not following an acceptance; rsp_data and rsp_err SHALL hold their last values while rsp_valid = 0.

Reset
REQ-030 While reset = 0: state = CLEAR, clear counter = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, busy = 1, req_ready = 0.
REQ-031 Array contents SHALL NOT be reset directly; the zero-fill SHALL start on the first edge after reset is released and complete after DEPTH cycles.
REQ-032 Reset asserted mid-CLEAR or mid-transaction SHALL discard any pending response and restart the clear from address 0 after release.

Verification
REQ-033 Release reset with DEPTH = 1024: busy = 1 for exactly 1024 cycles, req_ready = 0 throughout, then reads of addresses 0, 511 and 1023 return 0 with rsp_err = 0.
REQ-034 With RDW_MODE = 0: write 0x1_2345_6789_ABCD_EF01 to address 5, then read address 5 in the next cycle -> the write response shows the new data and the read response returns 0x1_2345_6789_ABCD_EF01.
REQ-035 With RDW_MODE = 1: address 7 holds 0xAA; write 0xBB to address 7 -> the response returns 0xAA; a following read returns 0xBB.
REQ-036 With DEPTH = 600, ADDR_WIDTH = 10: write 0xFF to address 700 -> rsp_err = 1, rsp_data = 0; a later read of address 700 -> rsp_err = 1.
REQ-037 Assert clear_req in cycle N, the cycle after a read of non-zero address 3 was accepted -> the read response for address 3 arrives in cycle N with the correct data; req_ready = 0 in cycle N and for the following DEPTH cycles; afterwards address 3 reads 0.
REQ-038 Pull reset low at counter = 300 during CLEAR -> outputs take their reset values immediately; after release the clear runs a full DEPTH cycles from address 0.
